// File: rtl/tower_ctrl_if.sv
// Bus between the unit spawners and the defender tower controller: hit
// strobes and unit positions in, HP, destroyed flags and return fire out.
interface tower_ctrl_if;
    logic       vsync;
    logic [2:0] idx_and, idx_or, idx_not, idx_nerd;
    logic [9:0] andX, andY, orX, orY, notX, notY, nerdX, nerdY;
    logic       towerrd, towerld, kingd;
    logic [7:0] hp_r, hp_l, hp_k;
    logic [2:0] attack_and, attack_or, attack_not, attack_nerd;

    modport master (
        output vsync, idx_and, idx_or, idx_not, idx_nerd,
               andX, andY, orX, orY, notX, notY, nerdX, nerdY,
        input  towerrd, towerld, kingd, hp_r, hp_l, hp_k,
               attack_and, attack_or, attack_not, attack_nerd
    );

    modport slave (
        input  vsync, idx_and, idx_or, idx_not, idx_nerd,
               andX, andY, orX, orY, notX, notY, nerdX, nerdY,
        output towerrd, towerld, kingd, hp_r, hp_l, hp_k,
               attack_and, attack_or, attack_not, attack_nerd
    );
endinterface

// File: rtl/tower_ctrl.sv
// Defender tower controller: once per frame it applies unit hits to the right,
// left and king towers, then resolves the towers' cooldown-gated return fire.
module tower_ctrl #(
    parameter int TOWER_HP    = 100,
    parameter int KING_HP     = 160,
    parameter int HIT_DMG     = 5,
    parameter int TOWER_DMG   = 2,
    parameter int FIRE_PERIOD = 60,
    parameter int RANGE       = 100
) (
    input logic         vga_clk,
    input logic         reset,
    tower_ctrl_if.slave bus
);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_COMMIT} state_t;

    localparam logic [21:0] RANGE_SQ = 22'(RANGE * RANGE);
    localparam logic [7:0]  CD_LAST  = 8'(FIRE_PERIOD - 1);

    state_t      r_state;
    logic        r_vsync_q, r_vsync_q2;
    logic [3:0]  r_pair;
    logic [11:0] r_inrange;
    logic [2:0]  r_idx [4];
    logic [9:0]  r_ux [4];
    logic [9:0]  r_uy [4];
    logic [7:0]  r_hp [3];
    logic [7:0]  r_cd [3];
    logic [2:0]  r_dead;
    logic [2:0]  r_attack [4];

    logic               w_tick;
    logic [1:0]         w_tower, w_unit;
    logic [9:0]         w_tx, w_ty;
    logic [7:0]         w_hpSel;
    logic signed [10:0] w_dx, w_dy;
    logic signed [21:0] w_dx2, w_dy2;
    logic [21:0]        w_dist;
    logic               w_inRange;

    logic [2:0]  w_hits [3];
    logic [10:0] w_dmg [3];
    logic [7:0]  w_newHp [3];
    logic [7:0]  w_cdNext [3];
    logic [1:0]  w_tgt [3];
    logic [2:0]  w_fire;
    logic [4:0]  w_acc [4];
    logic [2:0]  w_attack [4];

    assign w_tick  = r_vsync_q & ~r_vsync_q2;
    assign w_tower = r_pair[3:2];
    assign w_unit  = r_pair[1:0];

    // Shared distance datapath, stepped through the 12 tower/unit pairs in SCAN.
    always_comb begin
        w_tx    = 10'd440;
        w_ty    = 10'd240;
        w_hpSel = r_hp[2];
        case (w_tower)
            2'd0: begin w_tx = 10'd400; w_ty = 10'd80;  w_hpSel = r_hp[0]; end
            2'd1: begin w_tx = 10'd400; w_ty = 10'd400; w_hpSel = r_hp[1]; end
            default: ;
        endcase
        w_dx      = $signed({1'b0, r_ux[w_unit]}) - $signed({1'b0, w_tx});
        w_dy      = $signed({1'b0, r_uy[w_unit]}) - $signed({1'b0, w_ty});
        w_dx2     = 22'(w_dx) * 22'(w_dx);
        w_dy2     = 22'(w_dy) * 22'(w_dy);
        w_dist    = $unsigned(w_dx2) + $unsigned(w_dy2);
        w_inRange = (|{r_ux[w_unit], r_uy[w_unit]}) && (w_hpSel != 8'd0)
                    && (w_dist < RANGE_SQ);
    end

    // Commit-time damage intake, cooldowns and target selection; a tower's
    // liveness here is judged on its HP from before this frame's hits.
    always_comb begin
        for (int t = 0; t < 3; t++) begin
            w_hits[t] = 3'd0;
            for (int u = 0; u < 4; u++)
                if (r_idx[u] == 3'(t + 1)) w_hits[t] = w_hits[t] + 3'd1;
            w_dmg[t]   = 11'(w_hits[t]) * 11'(HIT_DMG);
            w_newHp[t] = ({3'b000, r_hp[t]} > w_dmg[t]) ? (r_hp[t] - w_dmg[t][7:0]) : 8'd0;

            w_tgt[t] = 2'd3;
            if (r_inrange[t*4])        w_tgt[t] = 2'd0;
            else if (r_inrange[t*4+1]) w_tgt[t] = 2'd1;
            else if (r_inrange[t*4+2]) w_tgt[t] = 2'd2;

            w_fire[t]   = 1'b0;
            w_cdNext[t] = 8'd0;
            if ((r_hp[t] != 8'd0) && (|r_inrange[t*4 +: 4])) begin
                if (r_cd[t] == CD_LAST) w_fire[t] = 1'b1;
                else                    w_cdNext[t] = r_cd[t] + 8'd1;
            end
            if (w_newHp[t] == 8'd0) w_cdNext[t] = 8'd0;
        end

        for (int u = 0; u < 4; u++) begin
            w_acc[u] = 5'd0;
            for (int t = 0; t < 3; t++)
                if (w_fire[t] && (w_tgt[t] == 2'(u))) w_acc[u] = w_acc[u] + 5'(TOWER_DMG);
            w_attack[u] = (w_acc[u] > 5'd7) ? 3'd7 : w_acc[u][2:0];
        end
    end

    // Frame FSM: snapshot on tick, scan all pairs, then commit in one cycle.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_vsync_q  <= 1'b0;
            r_vsync_q2 <= 1'b0;
            r_pair     <= 4'd0;
            r_inrange  <= 12'd0;
            r_dead     <= 3'b000;
            r_hp[0]    <= 8'(TOWER_HP);
            r_hp[1]    <= 8'(TOWER_HP);
            r_hp[2]    <= 8'(KING_HP);
            for (int t = 0; t < 3; t++) r_cd[t] <= 8'd0;
            for (int u = 0; u < 4; u++) begin
                r_idx[u]    <= 3'd0;
                r_ux[u]     <= 10'd0;
                r_uy[u]     <= 10'd0;
                r_attack[u] <= 3'd0;
            end
        end else begin
            r_vsync_q  <= bus.vsync;
            r_vsync_q2 <= r_vsync_q;
            case (r_state)
                S_IDLE: begin
                    if (w_tick) begin
                        r_idx[0]  <= bus.idx_and;  r_ux[0] <= bus.andX;  r_uy[0] <= bus.andY;
                        r_idx[1]  <= bus.idx_or;   r_ux[1] <= bus.orX;   r_uy[1] <= bus.orY;
                        r_idx[2]  <= bus.idx_not;  r_ux[2] <= bus.notX;  r_uy[2] <= bus.notY;
                        r_idx[3]  <= bus.idx_nerd; r_ux[3] <= bus.nerdX; r_uy[3] <= bus.nerdY;
                        r_pair    <= 4'd0;
                        r_inrange <= 12'd0;
                        r_state   <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    r_inrange[r_pair] <= w_inRange;
                    if (r_pair == 4'd11) r_state <= S_COMMIT;
                    else                 r_pair  <= r_pair + 4'd1;
                end
                S_COMMIT: begin
                    for (int t = 0; t < 3; t++) begin
                        r_hp[t] <= w_newHp[t];
                        r_cd[t] <= w_cdNext[t];
                        if (w_newHp[t] == 8'd0) r_dead[t] <= 1'b1;
                    end
                    for (int u = 0; u < 4; u++) r_attack[u] <= w_attack[u];
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.hp_r        = r_hp[0];
    assign bus.hp_l        = r_hp[1];
    assign bus.hp_k        = r_hp[2];
    assign bus.towerrd     = r_dead[0];
    assign bus.towerld     = r_dead[1];
    assign bus.kingd       = r_dead[2];
    assign bus.attack_and  = r_attack[0];
    assign bus.attack_or   = r_attack[1];
    assign bus.attack_not  = r_attack[2];
    assign bus.attack_nerd = r_attack[3];

endmodule

// File: tb/tb_tower_ctrl.sv
// Directed bench for tower_ctrl: a default instance plus a 12-HP instance
// used for the saturation and dead-tower cases.
module tb_tower_ctrl;

    logic vga_clk = 1'b0;
    logic reset;

    always #5 vga_clk = ~vga_clk;

    tower_ctrl_if bus ();
    tower_ctrl_if bus2 ();

    tower_ctrl u_dut (
        .vga_clk (vga_clk),
        .reset   (reset),
        .bus     (bus)
    );

    tower_ctrl #(.TOWER_HP(12)) u_dut2 (
        .vga_clk (vga_clk),
        .reset   (reset),
        .bus     (bus2)
    );

    int nChecks = 0;
    int nFails  = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        nChecks++;
        assert (observed === expected)
        else begin
            nFails++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // One frame: a single-cycle vsync pulse, then wait past the commit edge.
    task automatic applyStimulus();
        @(negedge vga_clk);
        bus.vsync  = 1'b1;
        bus2.vsync = 1'b1;
        @(negedge vga_clk);
        bus.vsync  = 1'b0;
        bus2.vsync = 1'b0;
        repeat (14) @(posedge vga_clk);
        #1;
        repeat (2) @(negedge vga_clk);
    endtask

    task automatic clearInputs();
        bus.vsync = 1'b0;
        bus.idx_and = 3'd0; bus.idx_or = 3'd0; bus.idx_not = 3'd0; bus.idx_nerd = 3'd0;
        bus.andX = 10'd0; bus.andY = 10'd0; bus.orX = 10'd0; bus.orY = 10'd0;
        bus.notX = 10'd0; bus.notY = 10'd0; bus.nerdX = 10'd0; bus.nerdY = 10'd0;
        bus2.vsync = 1'b0;
        bus2.idx_and = 3'd0; bus2.idx_or = 3'd0; bus2.idx_not = 3'd0; bus2.idx_nerd = 3'd0;
        bus2.andX = 10'd0; bus2.andY = 10'd0; bus2.orX = 10'd0; bus2.orY = 10'd0;
        bus2.notX = 10'd0; bus2.notY = 10'd0; bus2.nerdX = 10'd0; bus2.nerdY = 10'd0;
    endtask

    initial begin
        clearInputs();
        reset = 1'b1;
        repeat (3) @(negedge vga_clk);
        checkOutput("reset_hp_r", 32'(bus.hp_r), 100);
        checkOutput("reset_hp_l", 32'(bus.hp_l), 100);
        checkOutput("reset_hp_k", 32'(bus.hp_k), 160);
        checkOutput("reset_flags", 32'({bus.towerrd, bus.towerld, bus.kingd}), 0);
        checkOutput("reset_attack",
                    32'({bus.attack_and, bus.attack_or, bus.attack_not, bus.attack_nerd}), 0);
        checkOutput("reset_dut2_hp_l", 32'(bus2.hp_l), 12);
        reset = 1'b0;
        repeat (2) @(negedge vga_clk);

        // Reset in the middle of SCAN must abandon the frame.
        bus.idx_and = 3'd1;
        @(negedge vga_clk);
        bus.vsync = 1'b1;
        @(negedge vga_clk);
        bus.vsync = 1'b0;
        repeat (5) @(posedge vga_clk);
        #1 reset = 1'b1;
        @(negedge vga_clk);
        checkOutput("midscan_reset_hp_r", 32'(bus.hp_r), 100);
        checkOutput("midscan_reset_attack_and", 32'(bus.attack_and), 0);
        reset = 1'b0;
        repeat (20) @(negedge vga_clk);
        checkOutput("midscan_no_commit_hp_r", 32'(bus.hp_r), 100);

        // Next tick runs a clean frame; HP updates exactly at T14.
        @(negedge vga_clk);
        bus.vsync = 1'b1;
        @(negedge vga_clk);
        bus.vsync = 1'b0;
        repeat (13) @(posedge vga_clk);
        #1 checkOutput("latency_T13_hp_r", 32'(bus.hp_r), 100);
        @(posedge vga_clk);
        #1 checkOutput("latency_T14_hp_r", 32'(bus.hp_r), 95);
        repeat (3) @(negedge vga_clk);

        bus.idx_and = 3'd0;
        applyStimulus();
        checkOutput("no_hit_hp_r", 32'(bus.hp_r), 95);

        bus.idx_and = 3'd4; bus.idx_or = 3'd5; bus.idx_not = 3'd6; bus.idx_nerd = 3'd7;
        applyStimulus();
        checkOutput("ignored_idx_hp_r", 32'(bus.hp_r), 95);
        checkOutput("ignored_idx_hp_l", 32'(bus.hp_l), 100);
        checkOutput("ignored_idx_hp_k", 32'(bus.hp_k), 160);

        bus.idx_and = 3'd3; bus.idx_or = 3'd3; bus.idx_not = 3'd1; bus.idx_nerd = 3'd0;
        applyStimulus();
        checkOutput("multi_hit_hp_k", 32'(bus.hp_k), 150);
        checkOutput("multi_hit_hp_r", 32'(bus.hp_r), 90);
        checkOutput("multi_hit_hp_l", 32'(bus.hp_l), 100);
        bus.idx_and = 3'd0; bus.idx_or = 3'd0; bus.idx_not = 3'd0;

        // Saturation and sticky destroyed flag on the 12-HP instance.
        bus2.idx_or = 3'd2; bus2.idx_nerd = 3'd2;
        applyStimulus();
        checkOutput("sat_two_hits_hp_l", 32'(bus2.hp_l), 2);
        checkOutput("sat_two_hits_towerld", 32'(bus2.towerld), 0);
        bus2.idx_nerd = 3'd0;
        applyStimulus();
        checkOutput("sat_floor_hp_l", 32'(bus2.hp_l), 0);
        checkOutput("sat_floor_towerld", 32'(bus2.towerld), 1);
        bus2.idx_or = 3'd0;
        applyStimulus();
        checkOutput("sticky_towerld", 32'(bus2.towerld), 1);
        checkOutput("sticky_hp_l", 32'(bus2.hp_l), 0);
        checkOutput("dut2_hp_r_untouched", 32'(bus2.hp_r), 12);

        // Cooldown: 'not' near the right tower, 'and' on the king so the king
        // picks 'and'; a unit sits on the dead left tower of the second instance.
        bus.notX = 10'd400; bus.notY = 10'd150;
        bus.andX = 10'd440; bus.andY = 10'd240;
        bus2.orX = 10'd400; bus2.orY = 10'd400;
        bus2.idx_or = 3'd2;
        for (int f = 1; f < 60; f++) begin
            applyStimulus();
            checkOutput($sformatf("cooldown_wait_f%0d_not", f), 32'(bus.attack_not), 0);
            checkOutput($sformatf("dead_tower_f%0d_or", f), 32'(bus2.attack_or), 0);
        end
        applyStimulus();
        checkOutput("cooldown_fire_not", 32'(bus.attack_not), 2);
        checkOutput("cooldown_fire_king_and", 32'(bus.attack_and), 2);
        checkOutput("dead_tower_fire_or", 32'(bus2.attack_or), 0);
        checkOutput("dead_tower_hp_l", 32'(bus2.hp_l), 0);
        applyStimulus();
        checkOutput("cooldown_after_not", 32'(bus.attack_not), 0);
        checkOutput("cooldown_after_and", 32'(bus.attack_and), 0);
        bus2.idx_or = 3'd0;

        bus.notY = 10'd300;
        applyStimulus();
        checkOutput("out_of_range_not", 32'(bus.attack_not), 0);
        bus.notY = 10'd150;
        for (int f = 1; f < 60; f++) begin
            applyStimulus();
            checkOutput($sformatf("rearm_wait_f%0d_not", f), 32'(bus.attack_not), 0);
        end
        applyStimulus();
        checkOutput("rearm_fire_not", 32'(bus.attack_not), 2);

        // Priority and sum: right picks 'and' over 'or', king also picks 'and'.
        reset = 1'b1;
        repeat (2) @(negedge vga_clk);
        reset = 1'b0;
        clearInputs();
        bus.andX = 10'd420; bus.andY = 10'd150;
        bus.orX  = 10'd400; bus.orY  = 10'd90;
        repeat (2) @(negedge vga_clk);
        for (int f = 1; f < 60; f++) begin
            applyStimulus();
            checkOutput($sformatf("prio_wait_f%0d_and", f), 32'(bus.attack_and), 0);
        end
        applyStimulus();
        checkOutput("prio_sum_and", 32'(bus.attack_and), 4);
        checkOutput("prio_or", 32'(bus.attack_or), 0);
        checkOutput("prio_not", 32'(bus.attack_not), 0);
        checkOutput("prio_nerd", 32'(bus.attack_nerd), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
